// File: rtl/dadda_arb_pkg.sv
// Shared types, default sizes and the round-robin pick helper for the
// multiplier-sharing arbiter.
package dadda_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 8;
    localparam int MAX_REQ     = 8;
    localparam int PTR_W       = 3;

    typedef struct packed {
        logic             found;
        logic [PTR_W-1:0] idx;
    } pick_t;

    // Lanes at or above NUM_REQ are always zero, so wrapping at MAX_REQ
    // visits the live lanes in the same cyclic order as wrapping at NUM_REQ.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input logic [PTR_W-1:0]   ptr);
        pick_t            res;
        logic [PTR_W-1:0] j;
        res = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            j = ptr + PTR_W'(k);
            if (!res.found && valid[j]) begin
                res.found = 1'b1;
                res.idx   = j;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational pick from the pointer, pointer advances
// past the winner whenever a grant is issued.
module rr_arbiter
    import dadda_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               advance,
    output logic               found,
    output logic [ID_W-1:0]    idx,
    output logic [NUM_REQ-1:0] grant
);

    logic [PTR_W-1:0]   ptr_r;
    logic [MAX_REQ-1:0] valid_ext_s;
    pick_t              pick_s;

    // Winner selection, gated by the caller's grant opportunity.
    always_comb begin
        valid_ext_s              = '0;
        valid_ext_s[NUM_REQ-1:0] = valid;
        pick_s                   = rr_pick(valid_ext_s, ptr_r);
        found                    = pick_s.found & advance;
        idx                      = ID_W'(pick_s.idx);
        grant                    = '0;
        if (found) begin
            grant[idx] = 1'b1;
        end else begin
            grant = '0;
        end
    end

    // Pointer moves to the lane after the winner, wrapping at NUM_REQ.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (found) begin
            if (pick_s.idx == PTR_W'(NUM_REQ - 1)) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= pick_s.idx + PTR_W'(1);
            end
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/dadda_mul_arbiter.sv
// Shares one external 8x8 approximate multiplier among NUM_REQ requesters.
// Optional error statistics are enabled with the MUL_ERR_STATS_EN macro.
module dadda_mul_arbiter
    import dadda_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]       rsp_prod,
    output logic [WIDTH-1:0]         mul_in1,
    output logic [WIDTH-1:0]         mul_in2,
    input  logic [2*WIDTH-2:0]       mul_out,
    input  logic                     mul_ovf,
`ifdef MUL_ERR_STATS_EN
    input  logic                     stats_clr,
    output logic [31:0]              err_cnt,
    output logic [2*WIDTH-1:0]       max_err,
`endif
    output logic                     busy
);

    state_e               state_r;
    state_e               next_state_s;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;
    logic [ID_W-1:0]      id_r;
    logic [2*WIDTH-1:0]   prod_r;
    logic                 grant_en_s;
    logic                 grant_vld_s;
    logic [ID_W-1:0]      grant_idx_s;
    logic [NUM_REQ-1:0]   grant_s;
    logic [WIDTH-1:0]     sel_a_s;
    logic [WIDTH-1:0]     sel_b_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid   (req_valid),
        .advance (grant_en_s),
        .found   (grant_vld_s),
        .idx     (grant_idx_s),
        .grant   (grant_s)
    );

    // A grant opportunity exists when idle, or when the current response retires.
    always_comb begin
        grant_en_s = 1'b0;
        case (state_r)
            S_IDLE:  grant_en_s = 1'b1;
            S_RESP:  grant_en_s = rsp_ready;
            default: grant_en_s = 1'b0;
        endcase
    end

    // Next-state logic; back-to-back grant skips S_IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (grant_vld_s) begin
                    next_state_s = S_CALC;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_CALC: next_state_s = S_RESP;
            S_RESP: begin
                if (!rsp_ready) begin
                    next_state_s = S_RESP;
                end else if (grant_vld_s) begin
                    next_state_s = S_CALC;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            default: next_state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Operand mux driven by the one-hot grant.
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s[i]) begin
                sel_a_s = req_a[i*WIDTH +: WIDTH];
                sel_b_s = req_b[i*WIDTH +: WIDTH];
            end else begin
                sel_a_s = sel_a_s;
                sel_b_s = sel_b_s;
            end
        end
    end

    // Operand/tag capture on grant, product capture in S_CALC.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            id_r   <= '0;
            prod_r <= '0;
        end else begin
            if (grant_vld_s) begin
                a_r  <= sel_a_s;
                b_r  <= sel_b_s;
                id_r <= grant_idx_s;
            end else begin
                a_r  <= a_r;
                b_r  <= b_r;
                id_r <= id_r;
            end
            if (state_r == S_CALC) begin
                prod_r <= {mul_ovf, mul_out};
            end else begin
                prod_r <= prod_r;
            end
        end
    end

    assign req_ready = grant_s;
    assign rsp_valid = (state_r == S_RESP);
    assign busy      = (state_r != S_IDLE);
    assign rsp_id    = id_r;
    assign rsp_prod  = prod_r;
    assign mul_in1   = a_r;
    assign mul_in2   = b_r;

`ifdef MUL_ERR_STATS_EN
    logic [2*WIDTH-1:0] exact_s;
    logic [2*WIDTH-1:0] approx_s;
    logic [2*WIDTH-1:0] diff_s;
    logic [31:0]        err_cnt_r;
    logic [2*WIDTH-1:0] max_err_r;

    // Absolute error of the approximate product against the exact one.
    always_comb begin
        exact_s  = {{WIDTH{1'b0}}, a_r} * {{WIDTH{1'b0}}, b_r};
        approx_s = {mul_ovf, mul_out};
        if (exact_s >= approx_s) begin
            diff_s = exact_s - approx_s;
        end else begin
            diff_s = approx_s - exact_s;
        end
    end

    // Saturating error count and running maximum; clear wins over update.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            err_cnt_r <= 32'd0;
            max_err_r <= '0;
        end else if ((state_r == S_CALC) && (diff_s != '0)) begin
            if (err_cnt_r != 32'hFFFF_FFFF) begin
                err_cnt_r <= err_cnt_r + 32'd1;
            end else begin
                err_cnt_r <= err_cnt_r;
            end
            if (diff_s > max_err_r) begin
                max_err_r <= diff_s;
            end else begin
                max_err_r <= max_err_r;
            end
        end else begin
            err_cnt_r <= err_cnt_r;
            max_err_r <= max_err_r;
        end
    end

    assign err_cnt = err_cnt_r;
    assign max_err = max_err_r;
`endif

endmodule

// File: tb/tb_dadda_mul_arbiter.sv
// Scoreboard bench for dadda_mul_arbiter; the multiplier stand-in returns the
// exact product with its two LSBs cleared.
module tb_dadda_mul_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;
    localparam int ID_W    = 2;
    localparam int P_IDLE  = 0;
    localparam int P_STATS = 1;
    localparam int P_END   = 2;

    typedef struct {
        int          id;
        logic [15:0] prod;
        int          cyc;
    } rsp_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [15:0]              rsp_prod;
    logic [WIDTH-1:0]         mul_in1;
    logic [WIDTH-1:0]         mul_in2;
    logic [14:0]              mul_out;
    logic                     mul_ovf;
    logic                     busy;
    logic [15:0]              mul_full;
`ifdef MUL_ERR_STATS_EN
    logic                     stats_clr;
    logic [31:0]              err_cnt;
    logic [15:0]              max_err;
`endif

    // stimulus-owned
    logic [15:0] exp_prod [NUM_REQ];
    int          exp_gnt_id [64];
    int          exp_gnt_cyc [64];
    int          exp_gnt_n = 0;
    int          probe_seq = 0;
    int          probe_kind = 0;
    int          probe_err = 0;
    int          probe_max = 0;
    // monitor-owned
    int          checks = 0;
    int          errors = 0;
    int          gnt_rd = 0;
    int          probe_done = 0;
    int          gid;
    bit          rsp_open = 1'b0;
    rsp_t        rsp_q [$];
    rsp_t        cur;
    rsp_t        nr;
    int          cyc = 0;

    always #5 clk = ~clk;

    assign mul_full = ({8'h00, mul_in1} * {8'h00, mul_in2}) & 16'hFFFC;
    assign mul_out  = mul_full[14:0];
    assign mul_ovf  = mul_full[15];

    dadda_mul_arbiter #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH),
        .ID_W    (ID_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod),
        .mul_in1   (mul_in1),
        .mul_in2   (mul_in2),
        .mul_out   (mul_out),
        .mul_ovf   (mul_ovf),
`ifdef MUL_ERR_STATS_EN
        .stats_clr (stats_clr),
        .err_cnt   (err_cnt),
        .max_err   (max_err),
`endif
        .busy      (busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor/scoreboard: grants push expectations, responses pop and compare.
    always @(negedge clk) begin
        if (rst) begin
            rsp_q.delete();
            rsp_open = 1'b0;
        end else begin
            if (req_ready != '0) begin
                gid = 0;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_ready[i]) gid = i;
                end
                chk("ready_onehot", 32'($countones(req_ready)), 32'd1);
                chk("ready_without_valid", 32'(req_ready & ~req_valid), 32'd0);
                if (gnt_rd >= exp_gnt_n) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: got id %0d expected none (cycle %0d)", gid, cyc);
                end else begin
                    chk("grant_id", 32'(gid), 32'(exp_gnt_id[gnt_rd]));
                    chk("grant_cycle", 32'(cyc), 32'(exp_gnt_cyc[gnt_rd]));
                    gnt_rd++;
                end
                nr.id   = gid;
                nr.prod = exp_prod[gid];
                nr.cyc  = cyc;
                rsp_q.push_back(nr);
            end
            if (rsp_open) chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
            if (rsp_valid) begin
                if (!rsp_open) begin
                    if (rsp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got id %0d prod %0h expected none", rsp_id, rsp_prod);
                    end else begin
                        cur = rsp_q.pop_front();
                        chk("rsp_id", 32'(rsp_id), 32'(cur.id));
                        chk("rsp_prod", 32'(rsp_prod), 32'(cur.prod));
                        chk("rsp_latency", 32'(cyc - cur.cyc), 32'd2);
                        rsp_open = 1'b1;
                    end
                end else begin
                    chk("rsp_id_stable", 32'(rsp_id), 32'(cur.id));
                    chk("rsp_prod_stable", 32'(rsp_prod), 32'(cur.prod));
                end
                if (rsp_ready) rsp_open = 1'b0;
            end
        end
        if (probe_seq != probe_done) begin
            case (probe_kind)
                P_IDLE: begin
                    chk("idle_req_ready", 32'(req_ready), 32'd0);
                    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
                    chk("idle_rsp_id", 32'(rsp_id), 32'd0);
                    chk("idle_rsp_prod", 32'(rsp_prod), 32'd0);
                    chk("idle_mul_in1", 32'(mul_in1), 32'd0);
                    chk("idle_mul_in2", 32'(mul_in2), 32'd0);
                    chk("idle_busy", 32'(busy), 32'd0);
                end
`ifdef MUL_ERR_STATS_EN
                P_STATS: begin
                    chk("err_cnt", err_cnt, 32'(probe_err));
                    chk("max_err", 32'(max_err), 32'(probe_max));
                end
`endif
                P_END: begin
                    chk("pending_rsp", 32'(rsp_q.size()), 32'd0);
                    chk("grants_seen", 32'(gnt_rd), 32'(exp_gnt_n));
                    chk("rsp_open_at_end", 32'(rsp_open), 32'd0);
                end
                default: ;
            endcase
            probe_done = probe_seq;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        exp_prod[i]             = p;
        req_valid[i]            = 1'b1;
    endtask

    task automatic exp_gnt(input int id, input int c);
        exp_gnt_id[exp_gnt_n]  = id;
        exp_gnt_cyc[exp_gnt_n] = c;
        exp_gnt_n++;
    endtask

    task automatic probe(input int kind);
        probe_kind = kind;
        probe_seq++;
    endtask

    task automatic single(input int i, input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
        int c;
        c = cyc;
        set_req(i, a, b, p);
        exp_gnt(i, c);
        step(1);
        req_valid[i] = 1'b0;
        step(3);
    endtask

    initial begin
        int c;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
`ifdef MUL_ERR_STATS_EN
        stats_clr = 1'b0;
`endif
        step(2);
        probe(P_IDLE);
        step(1);
        rst = 1'b0;

        // single request, zero multiplicand
        single(0, 8'h00, 8'h5A, 16'h0000);

        // all four continuously valid after reset: 0,1,2,3,0,1 every 2 cycles
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        probe(P_IDLE);
        step(1);
        c = cyc;
        set_req(0, 8'h03, 8'h05, 16'h000C);
        set_req(1, 8'h10, 8'h10, 16'h0100);
        set_req(2, 8'hFF, 8'h02, 16'h01FC);
        set_req(3, 8'hFF, 8'hFF, 16'hFE00);
        for (int k = 0; k < 6; k++) exp_gnt(k % NUM_REQ, c + 2 * k);
        step(11);
        req_valid = '0;
        step(4);

        // response stalled 5 cycles with req2 pending
        c = cyc;
        rsp_ready = 1'b0;
        set_req(0, 8'h03, 8'h05, 16'h000C);
        exp_gnt(0, c);
        step(1);
        req_valid[0] = 1'b0;
        set_req(2, 8'hFF, 8'h02, 16'h01FC);
        step(6);
        rsp_ready = 1'b1;
        exp_gnt(2, c + 7);
        step(1);
        req_valid[2] = 1'b0;
        step(3);

        // pointer to 2, then req1 and req3 together: 3 first, then 1
        single(1, 8'h10, 8'h10, 16'h0100);
        c = cyc;
        set_req(1, 8'h10, 8'h10, 16'h0100);
        set_req(3, 8'hFF, 8'hFF, 16'hFE00);
        exp_gnt(3, c);
        exp_gnt(1, c + 2);
        step(1);
        req_valid[3] = 1'b0;
        step(2);
        req_valid[1] = 1'b0;
        step(3);

        // reset while in S_CALC discards the transaction and clears the pointer
        c = cyc;
        set_req(2, 8'hFF, 8'h02, 16'h01FC);
        exp_gnt(2, c);
        step(1);
        req_valid[2] = 1'b0;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        probe(P_IDLE);
        step(1);
        c = cyc;
        set_req(0, 8'h03, 8'h05, 16'h000C);
        set_req(3, 8'hFF, 8'hFF, 16'hFE00);
        exp_gnt(0, c);
        exp_gnt(3, c + 2);
        step(1);
        req_valid[0] = 1'b0;
        step(2);
        req_valid[3] = 1'b0;
        step(3);

`ifdef MUL_ERR_STATS_EN
        stats_clr = 1'b1;
        step(1);
        stats_clr = 1'b0;
        single(3, 8'hFF, 8'hFF, 16'hFE00);
        probe_err = 1;
        probe_max = 1;
        probe(P_STATS);
        step(1);
        single(0, 8'h03, 8'h05, 16'h000C);
        probe_err = 2;
        probe_max = 3;
        probe(P_STATS);
        step(1);
        stats_clr = 1'b1;
        step(1);
        stats_clr = 1'b0;
        probe_err = 0;
        probe_max = 0;
        probe(P_STATS);
        step(1);
`endif

        probe(P_END);
        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
